aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//   Iterative AES-128 encryption sequencer. It owns the 128-bit state register and performs the
//   add-round-key XOR internally. It fetches round keys from the key-schedule block over a
//   req/ack handshake and drives an external combinational round datapath
//   (SubBytes/ShiftRows/MixColumns). It sits between the block-level valid/ready stream and the
//   shared round logic.
// PARAMETERS
//   NR      10    number of rounds (1..15); round NR skips MixColumns
//   W       128   state / key width in bits (fixed 128 for AES)
// PORTS
//   clk        in   1    clock, all logic on rising edge
//   rst_n      in   1    synchronous active-low reset
//   in_valid   in   1    plaintext offered
//   in_ready   out  1    ctrl can accept plaintext (IDLE only)
//   pt         in   W    plaintext, sampled on in_valid&in_ready
//   out_valid  out  1    ciphertext available
//   out_ready  in   1    downstream accepts ciphertext
//   ct         out  W    ciphertext, stable while out_valid
//   key_req    out  1    round key requested
//   key_idx    out  4    index of requested round key (0..NR)
//   key_ack    in   1    1-cycle pulse: key_in valid for key_idx this cycle
//   key_in     in   W    round key
//   rnd_state  out  W    current state to round datapath (= state register)
//   rnd_last   out  1    1 when round datapath must skip MixColumns
//   rnd_res    in   W    combinational round datapath result for rnd_state
//   busy       out  1    1 in any state except IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state IDLE, rnd_cnt=0, state reg=0. Outputs: in_ready=1,
//     out_valid=0, key_req=0, key_idx=0, rnd_last=0, busy=0, ct=0, rnd_state=0.
//     Reset mid-operation aborts the block; the partial result is discarded and no out_valid follows.
//   FSM states IDLE, KEY_WAIT, DONE; all outputs are registered or decoded from state regs only.
//   IDLE: in_ready=1. On in_valid, latch pt into the state reg, rnd_cnt<=0, go to KEY_WAIT.
//   KEY_WAIT: key_req=1, key_idx=rnd_cnt, rnd_last=(rnd_cnt==NR), in_ready=0.
//     No key_ack: hold everything; key_req stays high for any number of wait cycles.
//     key_ack && rnd_cnt==0: state <= state ^ key_in (initial whitening).
//     key_ack && rnd_cnt>0: state <= rnd_res ^ key_in.
//     On ack with rnd_cnt<NR: rnd_cnt++, stay in KEY_WAIT. The next cycle presents the new key_idx
//       with key_req still high; back-to-back acks are legal.
//     On ack with rnd_cnt==NR: go to DONE; key_req=0 from the next cycle.
//   DONE: out_valid=1, ct=state reg. On out_ready, go to IDLE and clear out_valid next cycle.
//     out_ready may already be high on the first DONE cycle; the transfer completes that cycle.
//   Latency: with key_ack tied high, out_valid rises exactly NR+2 cycles after the accept edge
//     (12 for NR=10). Throughput is 1 block per NR+3 cycles minimum.
//   Ignored inputs:
//     - in_valid while not in IDLE; pt is not sampled.
//     - key_ack while key_req=0.
//     - out_ready while out_valid=0.
//   rnd_cnt saturates logically at NR; it never wraps and never exceeds NR.
//   ct is held stable from the first out_valid cycle through the handshake cycle.
// TESTING
//   1. FIPS-197 C.1: pt=00112233445566778899aabbccddeeff, key=000102..0f, bench key schedule
//      with zero-wait ack -> ct=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 12 cycles after accept.
//   2. Same vector, random 0-5 cycle ack delays -> identical ct; key_idx sequence 0..10, each held
//      until its ack; key_req never drops between rounds.
//   3. in_valid pulsed during KEY_WAIT with a different pt -> in_ready=0, ct unchanged from test 1.
//   4. out_ready=0 for 7 cycles in DONE -> out_valid and ct held; in_ready=0; accepted on the 8th
//      cycle, in_ready=1 the cycle after.
//   5. rst_n=0 for one cycle while rnd_cnt=5 -> next cycle: IDLE, in_ready=1, key_req=0,
//      out_valid=0, ct=0; a new vector then encrypts correctly.
//   6. Spurious key_ack in IDLE and DONE -> no state change; rnd_last=1 only while key_idx=10.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// Signal bundle tying the AES round sequencer to the block stream, the key schedule
// and the shared combinational round datapath.
interface aes_round_ctrl_if #(parameter int W = 128);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] pt;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] ct;
   logic         key_req;
   logic [3:0]   key_idx;
   logic         key_ack;
   logic [W-1:0] key_in;
   logic [W-1:0] rnd_state;
   logic         rnd_last;
   logic [W-1:0] rnd_res;
   logic         busy;

   modport slave (
      input  in_valid, pt, out_ready, key_ack, key_in, rnd_res,
      output in_ready, out_valid, ct, key_req, key_idx, rnd_state, rnd_last, busy
   );

   modport master (
      output in_valid, pt, out_ready, key_ack, key_in, rnd_res,
      input  in_ready, out_valid, ct, key_req, key_idx, rnd_state, rnd_last, busy
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state register, applies AddRoundKey and
// steps an external round datapath once per fetched round key.
module aes_round_ctrl #(
   parameter int NR = 10,
   parameter int W  = 128
) (
   input logic            clk,
   input logic            rst_n,
   aes_round_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      KEY_WAIT = 2'd1,
      DONE     = 2'd2
   } state_t;

   localparam logic [3:0] LastIdx = 4'(NR);

   state_t       r_fsm;
   state_t       w_fsmNext;
   logic [W-1:0] r_state;
   logic [3:0]   r_rndCnt;

   logic         w_loadPt;
   logic         w_loadKey;
   logic         w_cntInc;
   logic [W-1:0] w_keyBase;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsmNext;
      end
   end

   // Round counter only advances below the last index, so it can never pass NR.
   always_comb begin
      w_fsmNext = r_fsm;
      w_loadPt  = 1'b0;
      w_loadKey = 1'b0;
      w_cntInc  = 1'b0;
      unique case (r_fsm)
         IDLE: begin
            if (bus.in_valid) begin
               w_loadPt  = 1'b1;
               w_fsmNext = KEY_WAIT;
            end
         end
         KEY_WAIT: begin
            if (bus.key_ack) begin
               w_loadKey = 1'b1;
               if (r_rndCnt == LastIdx) begin
                  w_fsmNext = DONE;
               end else begin
                  w_cntInc = 1'b1;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_fsmNext = IDLE;
            end
         end
         default: begin
            w_fsmNext = IDLE;
         end
      endcase
   end

   assign w_keyBase = (r_rndCnt == 4'd0) ? r_state : bus.rnd_res;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= '0;
         r_rndCnt <= '0;
      end else begin
         if (w_loadPt) begin
            r_state <= bus.pt;
         end else if (w_loadKey) begin
            r_state <= w_keyBase ^ bus.key_in;
         end
         if (w_loadPt) begin
            r_rndCnt <= '0;
         end else if (w_cntInc) begin
            r_rndCnt <= r_rndCnt + 4'd1;
         end
      end
   end

   // Every output is a decode of the registered FSM state and counters.
   assign bus.in_ready  = (r_fsm == IDLE);
   assign bus.busy      = (r_fsm != IDLE);
   assign bus.key_req   = (r_fsm == KEY_WAIT);
   assign bus.key_idx   = (r_fsm == KEY_WAIT) ? r_rndCnt : 4'd0;
   assign bus.rnd_last  = (r_fsm == KEY_WAIT) && (r_rndCnt == LastIdx);
   assign bus.out_valid = (r_fsm == DONE);
   assign bus.ct        = (r_fsm == DONE) ? r_state : '0;
   assign bus.rnd_state = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: provides the key schedule and round datapath
// from a behavioural AES model and checks ciphertext, handshakes and reset behaviour.
module tb_aes_round_ctrl;

   localparam int NR = 10;
   localparam int W  = 128;
   localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_round_ctrl_if #(.W(W)) bus ();

   aes_round_ctrl #(.NR(NR), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errCnt = 0;
   int chkCnt = 0;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse (a^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] x;
      inv = 8'h01;
      x = a;
      for (int i = 1; i < 8; i++) begin
         x = gmul(x, x);
         inv = gmul(inv, x);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aesRound(input logic [127:0] s, input logic last);
      logic [7:0] b[16];
      logic [7:0] t[16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = b[rw + 4*((c + rw) % 4)];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
            t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
            t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
            t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
      return r;
   endfunction

   function automatic logic [127:0] roundKey(input logic [127:0] key, input int idx);
      logic [31:0] w[44];
      logic [31:0] tmp;
      logic [7:0] rcon;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])}
                  ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
   endfunction

   function automatic logic [127:0] aesEncrypt(input logic [127:0] p, input logic [127:0] key);
      logic [127:0] s;
      s = p ^ roundKey(key, 0);
      for (int r = 1; r <= NR; r++) s = aesRound(s, r == NR) ^ roundKey(key, r);
      return s;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   assign bus.rnd_res = aesRound(bus.rnd_state, bus.rnd_last);

   logic         ackSrv = 1'b0;
   logic         ackMan = 1'b0;
   logic [127:0] keySrv = '0;
   logic [127:0] keyMan = '0;
   logic [127:0] curKey = '0;
   int           maxDelay = 0;
   bit           monOn = 1'b0;

   assign bus.key_ack = ackSrv | ackMan;
   assign bus.key_in  = ackMan ? keyMan : keySrv;

   int   waitLeft = 0;
   int   idxLog[$];
   int   idxChanged = 0;
   int   reqDrop = 0;
   int   lastBad = 0;
   bit   holding = 1'b0;
   logic [3:0] heldIdx = 4'd0;

   // Key-schedule responder: answers each request after a random delay and logs what it saw.
   always @(negedge clk) begin
      ackSrv = 1'b0;
      if (monOn) begin
         if (bus.rnd_last !== (bus.key_idx == 4'(NR))) lastBad++;
         if (bus.busy === 1'b1 && bus.out_valid === 1'b0 && bus.key_req !== 1'b1) reqDrop++;
      end
      if (bus.key_req === 1'b1) begin
         if (holding && bus.key_idx != heldIdx) idxChanged++;
         holding = 1'b1;
         heldIdx = bus.key_idx;
         if (waitLeft == 0) begin
            ackSrv = 1'b1;
            keySrv = roundKey(curKey, int'(bus.key_idx));
            idxLog.push_back(int'(bus.key_idx));
            holding = 1'b0;
            waitLeft = int'($urandom_range(maxDelay, 0));
         end else begin
            waitLeft--;
         end
      end else begin
         holding = 1'b0;
         waitLeft = int'($urandom_range(maxDelay, 0));
      end
   end

   task automatic acceptBlock(input logic [127:0] p, output bit ok);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.pt = p;
      for (int i = 0; i < 40 && bus.in_ready !== 1'b1; i++) @(negedge clk);
      ok = (bus.in_ready === 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.pt = rand128();
   endtask

   task automatic waitDone(input int budget, output int cycles, output bit ok);
      cycles = 0;
      ok = 1'b0;
      while (cycles < budget && !ok) begin
         @(negedge clk);
         cycles++;
         ok = (bus.out_valid === 1'b1);
      end
   endtask

   task automatic releaseOut();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chkCnt++;
      if (bus.in_ready !== 1'b1) begin errCnt++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      chkCnt++;
      if (bus.out_valid !== 1'b0) begin errCnt++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      chkCnt++;
      if (bus.key_req !== 1'b0 || bus.key_idx !== 4'd0 || bus.rnd_last !== 1'b0) begin
         errCnt++;
         $display("[TB] FAIL reset_key_if: got req=%b idx=%0d last=%b want 0 0 0", bus.key_req, bus.key_idx, bus.rnd_last);
      end
      chkCnt++;
      if (bus.busy !== 1'b0) begin errCnt++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
      chkCnt++;
      if (bus.ct !== 128'h0 || bus.rnd_state !== 128'h0) begin
         errCnt++;
         $display("[TB] FAIL reset_data: got ct=%h rnd_state=%h want 0", bus.ct, bus.rnd_state);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      monOn = 1'b1;
   endtask

   task automatic test_fips();
      bit ok;
      int cyc;
      int logStart;
      bit bad;
      maxDelay = 0;
      curKey = FipsKey;
      logStart = idxLog.size();
      acceptBlock(FipsPt, ok);
      chkCnt++;
      if (!ok) begin errCnt++; $display("[TB] FAIL fips_accept: got in_ready timeout want accept"); end
      waitDone(40, cyc, ok);
      chkCnt++;
      if (!ok || cyc != NR + 2) begin
         errCnt++;
         $display("[TB] FAIL fips_latency: got done=%b after %0d cycles want %0d", ok, cyc, NR + 2);
      end
      chkCnt++;
      if (bus.ct !== FipsCt) begin errCnt++; $display("[TB] FAIL fips_ct: got %h want %h", bus.ct, FipsCt); end
      chkCnt++;
      if (bus.ct !== aesEncrypt(FipsPt, FipsKey)) begin
         errCnt++;
         $display("[TB] FAIL fips_ct_model: got %h want %h", bus.ct, aesEncrypt(FipsPt, FipsKey));
      end
      bad = 1'b0;
      if (idxLog.size() - logStart != NR + 1) bad = 1'b1;
      else for (int i = 0; i <= NR; i++) if (idxLog[logStart + i] != i) bad = 1'b1;
      chkCnt++;
      if (bad) begin errCnt++; $display("[TB] FAIL fips_key_idx_seq: got %0d acks want 0..%0d in order", idxLog.size() - logStart, NR); end
      releaseOut();
      @(negedge clk);
      chkCnt++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errCnt++;
         $display("[TB] FAIL fips_release: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_random_ack();
      bit ok;
      int cyc;
      int logStart;
      int drop0;
      int chg0;
      bit bad;
      logic [127:0] p;
      logic [127:0] exp;
      maxDelay = 5;
      for (int blk = 0; blk < 4; blk++) begin
         curKey = (blk == 0) ? FipsKey : rand128();
         p = (blk == 0) ? FipsPt : rand128();
         exp = (blk == 0) ? FipsCt : aesEncrypt(p, curKey);
         logStart = idxLog.size();
         drop0 = reqDrop;
         chg0 = idxChanged;
         acceptBlock(p, ok);
         waitDone(200, cyc, ok);
         chkCnt++;
         if (!ok || bus.ct !== exp) begin
            errCnt++;
            $display("[TB] FAIL rand_ack_ct blk%0d: got done=%b ct=%h want %h", blk, ok, bus.ct, exp);
         end
         bad = 1'b0;
         if (idxLog.size() - logStart != NR + 1) bad = 1'b1;
         else for (int i = 0; i <= NR; i++) if (idxLog[logStart + i] != i) bad = 1'b1;
         chkCnt++;
         if (bad || reqDrop != drop0 || idxChanged != chg0) begin
            errCnt++;
            $display("[TB] FAIL rand_ack_keyif blk%0d: got seq_bad=%b drops=%0d idx_changes=%0d want 0 0 0",
                     blk, bad, reqDrop - drop0, idxChanged - chg0);
         end
         releaseOut();
      end
   endtask

   task automatic test_in_valid_ignored();
      bit ok;
      int cyc;
      maxDelay = 2;
      curKey = FipsKey;
      acceptBlock(FipsPt, ok);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.pt = ~FipsPt;
         chkCnt++;
         if (bus.in_ready !== 1'b0) begin errCnt++; $display("[TB] FAIL busy_in_ready cyc%0d: got %b want 0", i, bus.in_ready); end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      waitDone(100, cyc, ok);
      chkCnt++;
      if (!ok || bus.ct !== FipsCt) begin
         errCnt++;
         $display("[TB] FAIL busy_ignore_ct: got done=%b ct=%h want %h", ok, bus.ct, FipsCt);
      end
      releaseOut();
   endtask

   task automatic test_backpressure();
      bit ok;
      int cyc;
      logic [127:0] p;
      logic [127:0] exp;
      maxDelay = 0;
      curKey = rand128();
      p = rand128();
      exp = aesEncrypt(p, curKey);
      acceptBlock(p, ok);
      waitDone(40, cyc, ok);
      chkCnt++;
      if (!ok) begin errCnt++; $display("[TB] FAIL bp_done: got timeout want out_valid"); end
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clk);
         chkCnt++;
         if (bus.out_valid !== 1'b1 || bus.ct !== exp || bus.in_ready !== 1'b0) begin
            errCnt++;
            $display("[TB] FAIL bp_hold cyc%0d: got ov=%b ir=%b ct=%h want 1 0 %h", i + 1, bus.out_valid, bus.in_ready, bus.ct, exp);
         end
      end
      @(negedge clk);
      chkCnt++;
      if (bus.out_valid !== 1'b1 || bus.ct !== exp) begin
         errCnt++;
         $display("[TB] FAIL bp_handshake_cycle: got ov=%b ct=%h want 1 %h", bus.out_valid, bus.ct, exp);
      end
      releaseOut();
      @(negedge clk);
      chkCnt++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errCnt++;
         $display("[TB] FAIL bp_release: got ir=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit found;
      bit sawValid;
      int cyc;
      logic [127:0] p;
      maxDelay = 0;
      curKey = rand128();
      acceptBlock(rand128(), ok);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         found = (bus.key_req === 1'b1 && bus.key_idx === 4'd5);
      end
      chkCnt++;
      if (!found) begin errCnt++; $display("[TB] FAIL midrst_reach_round5: got timeout want key_idx=5"); end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chkCnt++;
      if (bus.in_ready !== 1'b1 || bus.key_req !== 1'b0 || bus.out_valid !== 1'b0 || bus.ct !== 128'h0 || bus.busy !== 1'b0) begin
         errCnt++;
         $display("[TB] FAIL midrst_state: got ir=%b kr=%b ov=%b busy=%b ct=%h want 1 0 0 0 0",
                  bus.in_ready, bus.key_req, bus.out_valid, bus.busy, bus.ct);
      end
      sawValid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) sawValid = 1'b1;
      end
      chkCnt++;
      if (sawValid) begin errCnt++; $display("[TB] FAIL midrst_no_output: got out_valid=1 want 0"); end
      curKey = rand128();
      p = rand128();
      acceptBlock(p, ok);
      waitDone(40, cyc, ok);
      chkCnt++;
      if (!ok || bus.ct !== aesEncrypt(p, curKey)) begin
         errCnt++;
         $display("[TB] FAIL midrst_next_ct: got done=%b ct=%h want %h", ok, bus.ct, aesEncrypt(p, curKey));
      end
      releaseOut();
   endtask

   task automatic test_spurious();
      bit ok;
      int cyc;
      logic [127:0] snap;
      logic [127:0] p;
      @(negedge clk);
      snap = bus.rnd_state;
      ackMan = 1'b1;
      keyMan = rand128();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chkCnt++;
         if (bus.rnd_state !== snap || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errCnt++;
            $display("[TB] FAIL spur_idle cyc%0d: got state=%h busy=%b ov=%b want %h 0 0", i, bus.rnd_state, bus.busy, bus.out_valid, snap);
         end
      end
      ackMan = 1'b0;
      bus.out_ready = 1'b0;
      curKey = rand128();
      p = rand128();
      acceptBlock(p, ok);
      waitDone(40, cyc, ok);
      snap = aesEncrypt(p, curKey);
      chkCnt++;
      if (!ok || bus.ct !== snap) begin
         errCnt++;
         $display("[TB] FAIL spur_ct: got done=%b ct=%h want %h", ok, bus.ct, snap);
      end
      ackMan = 1'b1;
      keyMan = rand128();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chkCnt++;
         if (bus.out_valid !== 1'b1 || bus.ct !== snap || bus.rnd_state !== snap) begin
            errCnt++;
            $display("[TB] FAIL spur_done cyc%0d: got ov=%b ct=%h want 1 %h", i, bus.out_valid, bus.ct, snap);
         end
      end
      ackMan = 1'b0;
      releaseOut();
      @(negedge clk);
      chkCnt++;
      if (bus.in_ready !== 1'b1) begin errCnt++; $display("[TB] FAIL spur_release: got ir=%b want 1", bus.in_ready); end
      chkCnt++;
      if (lastBad != 0 || reqDrop != 0) begin
         errCnt++;
         $display("[TB] FAIL rnd_last_and_req: got last_bad=%0d req_drops=%0d want 0 0", lastBad, reqDrop);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.pt = '0;
      test_reset();
      test_fips();
      test_random_ack();
      test_in_valid_ignored();
      test_backpressure();
      test_reset_mid();
      test_spurious();
      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got simulation still running want finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
